pipeline_hazard_ctrl: RTL and testbench

- Sequencing controller for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM).
- Decides each cycle whether the PC and pipeline registers advance, hold, or get flushed / bubbled. Conditions:
  - load-use hazards (ID vs. ID/EX outputs)
  - taken branch / jump redirects resolved in EX
  - multi-cycle data-memory waits
- Drives write-enables and bubble/flush controls. The ID/EX register zeroes its control fields when id_ex_bubble is high.

---
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline advance/hold/flush sequencing for a five-stage pipeline.
// Optional perf counters when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs_address,
    input  logic [4:0]  id_rt_address,
    input  logic        id_uses_rt,
    input  logic        ex_MemRead,
    input  logic [4:0]  ex_rt_address,
    input  logic        ex_branch_taken,
    input  logic        ex_jump,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        pipe_freeze,
    output logic        stall,
    output logic [1:0]  state_out,
    output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } state_t;

    localparam logic [2:0]  FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_VAL  = 16'(MEM_TIMEOUT);

    state_t      state;
    logic [15:0] wait_cnt;
    logic [2:0]  flush_cnt;
    logic        timeout_q;

    logic load_use, redirect, mem_hold;
    logic freeze_c, flush_c, lu_c;

    assign load_use = ex_MemRead && (ex_rt_address != 5'd0) &&
                      ((ex_rt_address == id_rs_address) ||
                       (id_uses_rt && (ex_rt_address == id_rt_address)));
    assign redirect = ex_branch_taken | ex_jump;
    assign mem_hold = mem_req & ~mem_ready;

    // Priority freeze > redirect > load_use; MEM_WAIT ignores EX until released.
    always_comb begin
        freeze_c = 1'b0;
        flush_c  = 1'b0;
        lu_c     = 1'b0;
        case (state)
            RUN: begin
                if (mem_hold)      freeze_c = 1'b1;
                else if (redirect) flush_c  = 1'b1;
                else if (load_use) lu_c     = 1'b1;
            end
            MEM_WAIT: freeze_c = mem_hold;
            FLUSH: begin
                if (mem_hold) freeze_c = 1'b1;
                else          flush_c  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            pipe_freeze  = 1'b0;
            stall        = 1'b1;
        end else begin
            pc_write     = ~(freeze_c | lu_c);
            if_id_write  = ~(freeze_c | lu_c);
            if_id_flush  = flush_c;
            id_ex_bubble = flush_c | lu_c;
            pipe_freeze  = freeze_c;
            stall        = freeze_c | flush_c | lu_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= RUN;
            wait_cnt  <= 16'd0;
            flush_cnt <= 3'd0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_hold) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 16'd1;
                    end else if (redirect && (FLUSH_CYCLES > 1)) begin
                        state     <= FLUSH;
                        flush_cnt <= FLUSH_RELOAD;
                    end
                end
                MEM_WAIT: begin
                    if (!mem_hold) begin
                        state <= RUN;
                    end else if (wait_cnt == TIMEOUT_VAL) begin
                        timeout_q <= 1'b1;
                        state     <= RUN;
                    end else if (wait_cnt != 16'hFFFF) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                FLUSH: begin
                    // A freeze here drops the rest of the flush once memory releases.
                    if (mem_hold) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 16'd1;
                    end else if (redirect) begin
                        flush_cnt <= FLUSH_RELOAD;
                    end else if (flush_cnt <= 3'd1) begin
                        state <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign state_out   = state;
    assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall && !if_id_flush && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (if_id_flush && perf_flush_cnt != 32'hFFFF_FFFF)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FLUSH_CYCLES=3, MEM_TIMEOUT=8.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs_address, id_rt_address, ex_rt_address;
    logic       id_uses_rt, ex_MemRead, ex_branch_taken, ex_jump, mem_req, mem_ready;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, stall;
    logic [1:0] state_out;
    logic       mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .id_rs_address(id_rs_address), .id_rt_address(id_rt_address),
        .id_uses_rt(id_uses_rt), .ex_MemRead(ex_MemRead),
        .ex_rt_address(ex_rt_address), .ex_branch_taken(ex_branch_taken),
        .ex_jump(ex_jump), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze), .stall(stall),
        .state_out(state_out), .mem_timeout(mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // ctl = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, stall}
    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rt;
        logic       mem_read;
        logic [4:0] ex_rt;
        logic       br;
        logic       jmp;
        logic       mreq;
        logic       mrdy;
        logic [5:0] exp_ctl;
        logic [1:0] exp_state;
    } vec_t;

    localparam logic [5:0] ADV = 6'b110000, LU = 6'b000101, FL = 6'b111101,
                           FZ = 6'b000011, RST = 6'b001101;

    vec_t vecs[12];

    function automatic logic [5:0] ctl();
        return {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, stall};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                         input logic mr, input logic [4:0] ert, input logic br,
                         input logic jmp, input logic mreq, input logic mrdy);
        id_rs_address = rs; id_rt_address = rt; id_uses_rt = uses;
        ex_MemRead = mr; ex_rt_address = ert; ex_branch_taken = br;
        ex_jump = jmp; mem_req = mreq; mem_ready = mrdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ADV, 2'b00};
        vecs[1]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, LU,  2'b00};
        vecs[2]  = '{5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, LU,  2'b00};
        vecs[3]  = '{5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, ADV, 2'b00};
        vecs[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ADV, 2'b00};
        vecs[5]  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, ADV, 2'b00};
        vecs[6]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, FL,  2'b10};
        vecs[7]  = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, FL,  2'b10};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FZ,  2'b01};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, ADV, 2'b00};
        vecs[10] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, FZ,  2'b01};
        vecs[11] = '{5'd4, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, ADV, 2'b00};

        reset = 1'b0;
        idle();
        #1;
        check("reset_ctl", 32'(ctl()), 32'(RST));
        tick(); tick();
        check("reset_state", 32'(state_out), 32'd0);
        check("reset_timeout", 32'(mem_timeout), 32'd0);
        reset = 1'b1;
        #1;
        check("post_reset_ctl", 32'(ctl()), 32'(ADV));

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].mem_read,
                  vecs[i].ex_rt, vecs[i].br, vecs[i].jmp, vecs[i].mreq, vecs[i].mrdy);
            #1;
            check($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].exp_ctl));
            tick();
            check($sformatf("vec%0d_state", i), 32'(state_out), 32'(vecs[i].exp_state));
            idle();
            repeat (4) tick();
            check($sformatf("vec%0d_settle", i), 32'(state_out), 32'd0);
        end

        // Load-use then bubble in EX: advance resumes
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("lu_stall", 32'(ctl()), 32'(LU));
        tick();
        drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("lu_release", 32'(ctl()), 32'(ADV));
        idle();
        tick();

        // Redirect: three flush cycles, 00 -> 10 -> 10 -> 00
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("redir_c0_ctl", 32'(ctl()), 32'(FL));
        check("redir_c0_state", 32'(state_out), 32'd0);
        tick(); idle(); #1;
        check("redir_c1_ctl", 32'(ctl()), 32'(FL));
        check("redir_c1_state", 32'(state_out), 32'd2);
        tick();
        check("redir_c2_ctl", 32'(ctl()), 32'(FL));
        check("redir_c2_state", 32'(state_out), 32'd2);
        tick();
        check("redir_c3_ctl", 32'(ctl()), 32'(ADV));
        check("redir_c3_state", 32'(state_out), 32'd0);

        // Redirect again while flushing reloads the count
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        idle();
        tick();
        check("reload_state", 32'(state_out), 32'd2);
        repeat (3) tick();

        // Freeze during FLUSH drops the remaining flush
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        check("flush_frz_ctl", 32'(ctl()), 32'(FZ));
        tick();
        check("flush_frz_state", 32'(state_out), 32'd1);
        mem_ready = 1'b1;
        #1;
        check("flush_frz_rel", 32'(ctl()), 32'(ADV));
        tick(); idle(); #1;
        check("flush_frz_run", 32'(state_out), 32'd0);
        check("flush_frz_adv", 32'(ctl()), 32'(ADV));
        tick();

        // Priority: freeze beats jump and load-use, jump flushes after release
        drive(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        check("prio_c0", 32'(ctl()), 32'(FZ));
        for (int k = 1; k <= 3; k++) begin
            tick();
            check($sformatf("prio_wait%0d", k), 32'(ctl()), 32'(FZ));
            check($sformatf("prio_wstate%0d", k), 32'(state_out), 32'd1);
        end
        mem_ready = 1'b1;
        #1;
        check("prio_release", 32'(ctl()), 32'(ADV));
        tick();
        mem_req = 1'b0; mem_ready = 1'b0;
        #1;
        check("prio_jump_flush", 32'(ctl()), 32'(FL));
        check("prio_run_state", 32'(state_out), 32'd0);
        idle();
        repeat (4) tick();

        // Timeout after 8 wait cycles, sticky
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("to_wait%0d", k), 32'({state_out, mem_timeout}), 32'b010);
        end
        tick();
        check("to_state", 32'(state_out), 32'd0);
        check("to_flag", 32'(mem_timeout), 32'd1);
        idle();
        repeat (3) tick();
        check("to_sticky", 32'(mem_timeout), 32'd1);

        // Reset during MEM_WAIT
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("rst_mw_state", 32'(state_out), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mw_ctl", 32'(ctl()), 32'(RST));
        tick();
        check("rst_mw_after_state", 32'(state_out), 32'd0);
        check("rst_mw_after_to", 32'(mem_timeout), 32'd0);
        check("rst_mw_after_ctl", 32'(ctl()), 32'(RST));
        reset = 1'b1;
        idle();
        #1;
        check("rst_mw_release", 32'(ctl()), 32'(ADV));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
